// File: rtl/ack_transfer_pkg.sv
// rtl/ack_transfer_pkg.sv - shared modes, FSM states and parameter checks for ack_transfer_mc
`ifndef ACK_TRANSFER_PKG_SV
`define ACK_TRANSFER_PKG_SV

// Elaboration-time range check, used inside a module body (generate context).
`define ACK_CHECK_RANGE(tag, val, lo, hi) \
  if (((val) < (lo)) || ((val) > (hi))) begin \
    $error("ack_transfer: illegal parameter value %0d", (val)); \
  end

// Elaboration-time lower-bound check, for parameters with no upper limit.
`define ACK_CHECK_MIN(tag, val, lo) \
  if ((val) < (lo)) begin \
    $error("ack_transfer: illegal parameter value %0d", (val)); \
  end

`endif

package ack_transfer_pkg;

  // Per-channel mode encodings (input encoding, output encoding).
  localparam logic [1:0] MODE_T2P = 2'b00;
  localparam logic [1:0] MODE_T2T = 2'b01;
  localparam logic [1:0] MODE_P2T = 2'b10;
  localparam logic [1:0] MODE_P2P = 2'b11;

  // Pulse generator states; toggle-output channels never leave IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } ack_st_e;

endpackage

// File: rtl/ack_transfer_ch.sv
// rtl/ack_transfer_ch.sv - one ack transfer channel: sync, event detect, pulse/toggle regeneration
module ack_transfer_ch
  import ack_transfer_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter int         PULSE_LEN   = 10,
  parameter int         PEND_W      = 2,
  parameter logic [1:0] MODE        = MODE_T2P
) (
  input  logic clk,
  input  logic rst,
  input  logic ack_in,
  input  logic ovf_clr,
  output logic ack_out,
  output logic busy,
  output logic ovf
);

  `ACK_CHECK_RANGE(sync_stages, SYNC_STAGES, 0, 4)
  `ACK_CHECK_RANGE(pulse_len, PULSE_LEN, 1, 255)
  `ACK_CHECK_MIN(pend_w, PEND_W, 1)

  localparam logic              TOGGLE_IN = !((MODE == MODE_P2T) || (MODE == MODE_P2P));
  localparam logic              PULSE_OUT = (MODE == MODE_T2P) || (MODE == MODE_P2P);
  localparam logic [7:0]        LEN8      = 8'(PULSE_LEN);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  logic              s;
  logic              s_d;
  logic              evt;
  ack_st_e           state, state_n;
  logic [7:0]        cnt, cnt_n;
  logic [PEND_W-1:0] pend, pend_n;
  logic              ack_q, ack_n;
  logic              ovf_q, ovf_n;
  logic              inc, start, ovf_set;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = ack_in;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;

    // Synchroniser chain for a possibly foreign-domain ack.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= ack_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_q[i] <= sync_q[i-1];
        end
      end
    end

    assign s = sync_q[SYNC_STAGES-1];
  end

  // Previous synchronised level for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_d <= 1'b0;
    else     s_d <= s;
  end

  assign evt = TOGGLE_IN ? (s ^ s_d) : (s & ~s_d);

  // Channel state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      pend  <= '0;
      ack_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pend  <= pend_n;
      ack_q <= ack_n;
      ovf_q <= ovf_n;
    end
  end

  // Next state: pulse FSM for pulse outputs, plain toggle otherwise.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ack_n   = ack_q;
    inc     = 1'b0;
    start   = 1'b0;
    if (PULSE_OUT) begin
      case (state)
        IDLE: begin
          if (evt) begin
            state_n = PULSE;
            cnt_n   = 8'd1;
            ack_n   = 1'b1;
          end
        end
        PULSE: begin
          inc = evt;
          if (cnt == LEN8) begin
            state_n = GAP;
            cnt_n   = 8'd0;
            ack_n   = 1'b0;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
        GAP: begin
          inc = evt;
          if ((pend != '0) || evt) begin
            state_n = PULSE;
            cnt_n   = 8'd1;
            ack_n   = 1'b1;
            start   = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = 8'd0;
          ack_n   = 1'b0;
        end
      endcase
    end else begin
      ack_n = ack_q ^ evt;
    end
  end

  // Pending count: a start with pend==0 is always paired with an event, so no underflow.
  always_comb begin
    pend_n  = pend;
    ovf_set = 1'b0;
    if (inc && !start) begin
      if (pend == PEND_MAX) ovf_set = 1'b1;
      else                  pend_n  = pend + PEND_W'(1);
    end else if (start && !inc) begin
      pend_n = pend - PEND_W'(1);
    end
    ovf_n = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  assign ack_out = ack_q;
  assign busy    = (state != IDLE);
  assign ovf     = ovf_q;

endmodule

// File: rtl/ack_transfer_mc.sv
// rtl/ack_transfer_mc.sv - multi-channel acknowledge transfer top
module ack_transfer_mc
  import ack_transfer_pkg::*;
#(
  parameter int                  NUM_CH      = 4,
  parameter int                  SYNC_STAGES = 2,
  parameter int                  PULSE_LEN   = 10,
  parameter int                  PEND_W      = 2,
  parameter logic [2*NUM_CH-1:0] MODE        = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ack_in,
  input  logic [NUM_CH-1:0] ovf_clr,
  output logic [NUM_CH-1:0] ack_out,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] ovf
);

  `ACK_CHECK_MIN(num_ch, NUM_CH, 1)

  // Independent channels; only clk and rst are shared.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ack_transfer_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .PULSE_LEN  (PULSE_LEN),
      .PEND_W     (PEND_W),
      .MODE       (MODE[2*i +: 2])
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .ack_in (ack_in[i]),
      .ovf_clr(ovf_clr[i]),
      .ack_out(ack_out[i]),
      .busy   (busy[i]),
      .ovf    (ovf[i])
    );
  end

endmodule

// File: tb/tb_ack_transfer_mc.sv
// tb/tb_ack_transfer_mc.sv - directed self-checking bench for ack_transfer_mc
module tb_ack_transfer_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ack_in, ovf_clr, ack_out, busy, ovf;
  logic [0:0] ack_in2, ovf_clr2, ack_out2, busy2, ovf2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ack_transfer_mc #(
    .NUM_CH(4), .SYNC_STAGES(2), .PULSE_LEN(10), .PEND_W(2), .MODE(8'b11_10_01_00)
  ) dut (
    .clk(clk), .rst(rst), .ack_in(ack_in), .ovf_clr(ovf_clr),
    .ack_out(ack_out), .busy(busy), .ovf(ovf)
  );

  ack_transfer_mc #(
    .NUM_CH(1), .SYNC_STAGES(0), .PULSE_LEN(10), .PEND_W(1), .MODE(2'b00)
  ) dut2 (
    .clk(clk), .rst(rst), .ack_in(ack_in2), .ovf_clr(ovf_clr2),
    .ack_out(ack_out2), .busy(busy2), .ovf(ovf2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic in_rng(input int e, input int lo, input int hi);
    return (e >= lo) && (e <= hi);
  endfunction

  initial begin
    rst      = 1'b1;
    ack_in   = '0;
    ovf_clr  = '0;
    ack_in2  = '0;
    ovf_clr2 = '0;
    repeat (2) tick();
    check("rst_ack", 32'(ack_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_dut2", 32'({ack_out2, busy2, ovf2}), 0);
    rst = 1'b0;
    repeat (2) tick();

    // T2P single event on ch0
    ack_in[0] = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      tick();
      check($sformatf("t2p_ack e%0d", e), 32'(ack_out[0]), 32'(in_rng(e, 3, 12)));
      check($sformatf("t2p_busy e%0d", e), 32'(busy[0]), 32'(in_rng(e, 3, 13)));
      check($sformatf("t2p_other e%0d", e), 32'(ack_out[3:1]), 0);
    end

    // T2P three queued events
    ack_in[0] = 1'b0;
    for (int e = 1; e <= 38; e++) begin
      tick();
      check($sformatf("q_ack e%0d", e), 32'(ack_out[0]),
            32'(in_rng(e, 3, 12) || in_rng(e, 14, 23) || in_rng(e, 25, 34)));
      check($sformatf("q_busy e%0d", e), 32'(busy[0]), 32'(in_rng(e, 3, 35)));
      check($sformatf("q_pend e%0d", e), 32'(dut.g_ch[0].u_ch.pend),
            in_rng(e, 11, 13) ? 2 : ((in_rng(e, 7, 10) || in_rng(e, 14, 24)) ? 1 : 0));
      check($sformatf("q_ovf e%0d", e), 32'(ovf[0]), 0);
      if (e == 4) ack_in[0] = 1'b1;
      if (e == 8) ack_in[0] = 1'b0;
    end

    // Reset in pulse cycle 5 with one event pending
    ack_in[0] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 4) ack_in[0] = 1'b0;
    end
    check("mid_ack", 32'(ack_out[0]), 1);
    check("mid_pend", 32'(dut.g_ch[0].u_ch.pend), 1);
    check("mid_cnt", 32'(dut.g_ch[0].u_ch.cnt), 5);
    #2 rst = 1'b1;
    #1;
    check("arst_ack", 32'(ack_out[0]), 0);
    check("arst_busy", 32'(busy[0]), 0);
    check("arst_pend", 32'(dut.g_ch[0].u_ch.pend), 0);
    check("arst_cnt", 32'(dut.g_ch[0].u_ch.cnt), 0);
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      tick();
      check($sformatf("post_rst e%0d", e), 32'({ack_out, busy}), 0);
    end

    // All channels at once: T2P, T2T, P2T, P2P
    ack_in = 4'b1111;
    for (int e = 1; e <= 15; e++) begin
      tick();
      check($sformatf("ind_ack0 e%0d", e), 32'(ack_out[0]), 32'(in_rng(e, 3, 12)));
      check($sformatf("ind_ack1 e%0d", e), 32'(ack_out[1]), 32'(e >= 3));
      check($sformatf("ind_ack2 e%0d", e), 32'(ack_out[2]), 32'(e >= 3));
      check($sformatf("ind_ack3 e%0d", e), 32'(ack_out[3]), 32'(in_rng(e, 3, 12)));
      check($sformatf("ind_busy e%0d", e), 32'(busy),
            in_rng(e, 3, 13) ? 32'h9 : 32'h0);
      check($sformatf("ind_ovf e%0d", e), 32'(ovf), 0);
      if (e == 5) ack_in[3:2] = 2'b00;
    end

    // T2T: four toggles on ch1
    ack_in[1] = 1'b0;
    for (int e = 1; e <= 17; e++) begin
      int n;
      tick();
      n = int'(e >= 3) + int'(e >= 7) + int'(e >= 11) + int'(e >= 15);
      check($sformatf("t2t_ack e%0d", e), 32'(ack_out[1]), 32'(1 ^ (n % 2)));
      check($sformatf("t2t_busy e%0d", e), 32'(busy[1]), 0);
      check($sformatf("t2t_ch2 e%0d", e), 32'(ack_out[2]), 1);
      if (e == 4)  ack_in[1] = 1'b1;
      if (e == 8)  ack_in[1] = 1'b0;
      if (e == 12) ack_in[1] = 1'b1;
    end

    // Overflow with PEND_W=1, no synchroniser
    ack_in2 = 1'b1;
    for (int e = 1; e <= 35; e++) begin
      tick();
      check($sformatf("ovf_ack e%0d", e), 32'(ack_out2),
            32'(in_rng(e, 1, 10) || in_rng(e, 12, 21) || in_rng(e, 23, 32)));
      check($sformatf("ovf_busy e%0d", e), 32'(busy2), 32'(in_rng(e, 1, 33)));
      check($sformatf("ovf_flag e%0d", e), 32'(ovf2),
            32'(in_rng(e, 5, 12) || in_rng(e, 16, 17)));
      if (e == 2)  ack_in2 = 1'b0;
      if (e == 4)  ack_in2 = 1'b1;
      if (e == 12) ovf_clr2 = 1'b1;
      if (e == 13) begin ovf_clr2 = 1'b0; ack_in2 = 1'b0; end
      if (e == 15) begin ovf_clr2 = 1'b1; ack_in2 = 1'b1; end
      if (e == 16) ovf_clr2 = 1'b0;
      if (e == 17) ovf_clr2 = 1'b1;
      if (e == 18) ovf_clr2 = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ack_transfer_mc.md
# ack_transfer_mc

Multi-channel acknowledge transfer block, parametrised successor of the single-channel edge/level ack converters. Each channel synchronises an incoming ack (toggle or pulse encoded), detects events, and regenerates them as either a stretched pulse or a toggle in the local `clk` domain. Channels run in a per-channel mode. Pulse-output channels queue events that arrive while a pulse is in flight instead of dropping them, and flag overflow. Sits between PE clock domains and the local router/NI handshake logic.

## Interface
- `NUM_CH`, 4: number of independent channels (≥1).
- `SYNC_STAGES`, 2: synchroniser depth on `ack_in`, legal 0..4. Use 0 only for same-domain inputs.
- `PULSE_LEN`, 10: high time of a generated pulse in `clk` cycles, legal 1..255.
- `PEND_W`, 2: width of the per-channel pending-event counter (≥1).
- `MODE`, all zeros: `2*NUM_CH` bits, 2 bits per channel (ch i at `[2i+1:2i]`).
  - 00 T2P: toggle in, pulse out.
  - 01 T2T: toggle in, toggle out.
  - 10 P2T: pulse in, toggle out.
  - 11 P2P: pulse in, pulse out.
- `clk` in 1: sole clock.
- `rst` in 1: reset, asynchronous, active-high.
- `ack_in` in NUM_CH: raw ack per channel, possibly from a foreign clock domain.
- `ack_out` out NUM_CH: regenerated ack, registered.
- `busy` out NUM_CH: channel is in PULSE or GAP.
- `ovf` out NUM_CH: sticky flag, set when a pending-counter event is lost.
- `ovf_clr` in NUM_CH: synchronous clear of `ovf`.

## Operation
- **Synchroniser and event detect (per channel)**
  - `SYNC_STAGES` flops, reset 0. `s` is the last stage, or `ack_in` when `SYNC_STAGES`=0.
  - `s_d` is `s` registered.
  - `event` is combinational: `s != s_d` in toggle-in modes; `s & ~s_d` in pulse-in modes.
- **Toggle-out modes (T2T, P2T)**
  - Each `event` inverts `ack_out` at the next edge.
  - `busy`, pending counter and `ovf` stay 0.
- **Pulse-out modes (T2P, P2P)**: FSM with states IDLE, PULSE, GAP and a cycle counter `cnt` (8 bits).
  - IDLE, `event`: go to PULSE with `cnt`=1 and `ack_out`=1.
  - PULSE: `cnt` increments each cycle. When `cnt`==`PULSE_LEN`, go to GAP with `ack_out`=0 and `cnt`=0.
  - GAP lasts exactly 1 cycle. If `pend`>0 or `event`, go to PULSE (`cnt`=1, `ack_out`=1); otherwise go to IDLE.
  - `pend` arithmetic: `pend_next = pend + inc - dec`.
    - `inc` = `event` while in PULSE or GAP.
    - `dec` = 1 when GAP→PULSE is taken. The start consumes the simultaneous event if `pend`==0.
    - Net change on a simultaneous inc and dec is 0.
  - Saturation: if `pend` == 2^PEND_W−1 and the net change would be +1, `pend` holds and `ovf` is set.
- **Sticky overflow**: `ovf_clr` clears `ovf`. A set in the same cycle wins over the clear.
- **Channel independence**: channels share only `clk` and `rst`; there is no cross-channel interaction.

## Timing
- **Reset**: all sync flops, `s_d`, `ack_out`, `busy`, `ovf`, `pend` and `cnt` are 0; the FSM is in IDLE.
- **Reset mid-operation**: an in-flight pulse is truncated and pending events are discarded. After release, the first edge sees `s_d`=0, so a synchronised `ack_in`=1 in toggle modes produces one event.
- **Latency**: a stable `ack_in` change set up before edge k reaches `ack_out` at edge k+`SYNC_STAGES`.
  - Equivalently, `SYNC_STAGES`+1 edges after the change.
  - With `SYNC_STAGES`=0, `ack_out` updates at the first edge.
- **Pulse shape**: exactly `PULSE_LEN` cycles high, then at least 1 cycle low between back-to-back pulses.
- **Throughput**: at most 1 pulse per `PULSE_LEN`+1 cycles per channel.
- **Input requirement (toggle-in)**: each input level must be held at least `SYNC_STAGES`+1 cycles to be seen.
- **Input requirement (pulse-in)**: pulses must be high and low at least `SYNC_STAGES`+1 cycles each. Shorter activity may be missed; this is not flagged.
- **`PULSE_LEN`=1**: high 1 cycle, GAP 1 cycle.

## Structure
- **Package `ack_transfer_pkg`**:
  - Mode localparams `MODE_T2P`, `MODE_T2T`, `MODE_P2T`, `MODE_P2P`.
  - FSM state enum `ack_st_e` {IDLE, PULSE, GAP}.
  - Parameter-range check macros.
- **Sub-module `ack_transfer_ch`**: one channel (sync chain, edge detect, FSM, pending counter, `ovf`), with `MODE` as a 2-bit parameter.
- **Top level**: generate-loop of `NUM_CH` instances.
- **Elaboration checks**: elaboration fails on an illegal `SYNC_STAGES`, `PULSE_LEN` or `PEND_W`.

## Test plan
- **T2P single event**: ch0 T2P, `SYNC_STAGES`=2, `PULSE_LEN`=10; `ack_in[0]` toggles 0→1 before edge 1 → `ack_out[0]` high at edges 3..12 and low at 13; `busy` high at edges 3..13.
- **T2P queued events**: 3 toggles spaced 4 cycles apart, the first starting a pulse → 3 pulses of 10 cycles, each separated by exactly 1 low cycle; `pend` peaks at 2; `ovf`=0.
- **Overflow**: `PEND_W`=1 and 3 events during one pulse → `ovf` set on the 3rd; 2 pulses total; `ovf_clr` and a new overflow in the same cycle → `ovf` stays 1.
- **Toggle and pulse-in toggle modes**: T2T with 4 input toggles → `ack_out` toggles 4 times, each `SYNC_STAGES`+1 edges after its input, `busy` never asserted; P2T input pulse of 5 cycles → single `ack_out` toggle.
- **Reset mid-pulse**: `rst` asserted in cycle 5 of a pulse with `pend`=1 → `ack_out`, `busy`, `pend` and `cnt` are 0 asynchronously, and no pulse follows release.
- **Channel independence**: `NUM_CH`=4, `MODE`=8'b11_10_01_00, simultaneous events on all channels → each channel responds per its mode with identical latency and no cross-talk.
